// File: rtl/gate_response_checker_if.sv
// gate_response_checker_if
//   Groups the signals between the built-in self-test checker and its
//   environment: the sweep handshake, the stimulus driven into gate_logic,
//   the six gate outputs fed back, and the result reporting.
//   slave  : checker side (gate_response_checker)
//   master : environment side (gate_logic wiring / testbench)
// Ports (signals):
//   start               sweep request
//   drive_a, drive_b    stimulus to gate_logic
//   c..h                gate_logic outputs (AND, OR, NAND, NOR, XOR, XNOR)
//   busy, done, pass    sweep status / result
//   err_count[ERR_W]    saturating mismatch count of last sweep
//   err_vec[6]          sticky per-output mismatch flags, bit0=c .. bit5=h
interface gate_response_checker_if #(
    parameter int ERR_W = 4
);
    logic             start;
    logic             drive_a;
    logic             drive_b;
    logic             c, d, e, f, g, h;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [5:0]       err_vec;

    modport slave (
        input  start, c, d, e, f, g, h,
        output drive_a, drive_b, busy, done, pass, err_count, err_vec
    );

    modport master (
        output start, c, d, e, f, g, h,
        input  drive_a, drive_b, busy, done, pass, err_count, err_vec
    );
endinterface

// File: rtl/gate_response_checker.sv
// gate_response_checker
//   On-chip checker for gate_logic. A sweep drives a/b through 00,01,10,11
//   (a is MSB), waits SETTLE_CYCLES per vector, then compares the six gate
//   outputs with the expected Boolean functions. Reports pass/fail, a
//   saturating mismatch count and a sticky per-output mismatch bitmap.
// Parameters:
//   SETTLE_CYCLES  cycles between driving a/b and sampling c..h (1..15)
//   ERR_W          width of err_count
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    gate_response_checker_if.slave (start, drive_a/b, c..h,
//          busy, done, pass, err_count, err_vec)
// Optional feature macro: GATE_CHK_STOP_ON_FAIL_EN
//   When defined, the first SAMPLE with any mismatch ends the sweep.
module gate_response_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gate_response_checker_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, DRIVE, SETTLE, SAMPLE, DONE
    } state_t;

    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;
    localparam int               SW          = ERR_W + 3;

    state_t           state, state_nxt;
    logic [1:0]       idx, idx_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic [ERR_W-1:0] err_count, err_count_nxt;
    logic [5:0]       err_vec, err_vec_nxt;
    logic             pass, pass_nxt;

    logic             va, vb;
    logic [5:0]       expect_v, observed, mism;
    logic [2:0]       pop;
    logic [SW-1:0]    sum;

    // Expected outputs for the vector currently driven.
    assign va       = idx[1];
    assign vb       = idx[0];
    assign expect_v = {~(va ^ vb), va ^ vb, ~(va | vb), ~(va & vb), va | vb, va & vb};
    assign observed = {bus.h, bus.g, bus.f, bus.e, bus.d, bus.c};

    // Case inequality so X/Z on a gate output is flagged as a mismatch.
    always_comb begin
        mism = '0;
        pop  = '0;
        for (int i = 0; i < 6; i++) begin
            mism[i] = (observed[i] !== expect_v[i]);
            pop     = pop + 3'(mism[i]);
        end
        sum = SW'(err_count) + SW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            err_count <= '0;
            err_vec   <= '0;
            pass      <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            cnt       <= cnt_nxt;
            err_count <= err_count_nxt;
            err_vec   <= err_vec_nxt;
            pass      <= pass_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        cnt_nxt       = cnt;
        err_count_nxt = err_count;
        err_vec_nxt   = err_vec;
        pass_nxt      = pass;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    err_count_nxt = '0;
                    err_vec_nxt   = '0;
                    idx_nxt       = '0;
                    state_nxt     = DRIVE;
                end
            end
            DRIVE: begin
                cnt_nxt   = SETTLE_LOAD;
                state_nxt = SETTLE;
            end
            SETTLE: begin
                if (cnt == '0) state_nxt = SAMPLE;
                else           cnt_nxt   = cnt - 4'd1;
            end
            SAMPLE: begin
                err_vec_nxt   = err_vec | mism;
                err_count_nxt = (sum > SW'(ERR_MAX)) ? ERR_MAX : sum[ERR_W-1:0];
`ifdef GATE_CHK_STOP_ON_FAIL_EN
                if (idx == 2'd3 || mism != '0) begin
`else
                if (idx == 2'd3) begin
`endif
                    // pass is latched on entry to DONE so it is valid alongside done.
                    pass_nxt  = (err_vec_nxt == '0);
                    state_nxt = DONE;
                end else begin
                    idx_nxt   = idx + 2'd1;
                    state_nxt = DRIVE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.busy      = (state == DRIVE) || (state == SETTLE) || (state == SAMPLE);
    assign bus.done      = (state == DONE);
    assign bus.drive_a   = bus.busy & idx[1];
    assign bus.drive_b   = bus.busy & idx[0];
    assign bus.pass      = pass;
    assign bus.err_count = err_count;
    assign bus.err_vec   = err_vec;
endmodule

// File: tb/tb_gate_response_checker.sv
module tb_gate_response_checker;
    localparam int ERR_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   fault = 0;  // 0 good, 1 g stuck 0, 2 all inverted, 3 c stuck 1
    int   done_cycle;
    logic [1:0] trace [0:63];

    gate_response_checker_if #(.ERR_W(ERR_W)) bus ();

    gate_response_checker #(.SETTLE_CYCLES(2), .ERR_W(ERR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // gate_logic model with injectable faults
    always_comb begin
        logic a, b;
        a = bus.drive_a;
        b = bus.drive_b;
        bus.c = a & b;
        bus.d = a | b;
        bus.e = ~(a & b);
        bus.f = ~(a | b);
        bus.g = a ^ b;
        bus.h = ~(a ^ b);
        case (fault)
            1: bus.g = 1'b0;
            2: begin
                bus.c = ~(a & b); bus.d = ~(a | b); bus.e = a & b;
                bus.f = a | b;    bus.g = ~(a ^ b); bus.h = a ^ b;
            end
            3: bus.c = 1'b1;
            default: ;
        endcase
    end

    // Pulse start, then record drive values per cycle (cycle 1 = first DRIVE)
    // and the cycle in which done is seen; 0 if it never appears.
    task automatic run_sweep();
        done_cycle = 0;
        @(negedge clk) bus.start = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
            trace[n] = {bus.drive_a, bus.drive_b};
            if (bus.done && done_cycle == 0) done_cycle = n;
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        rst_n = 1'b0;
        #12;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %b want 0", bus.pass); end
        checks++; if ({bus.drive_a, bus.drive_b} !== 2'b00) begin errors++; $display("FAIL reset_drive got %b want 00", {bus.drive_a, bus.drive_b}); end
        checks++; if (bus.err_count !== 4'd0) begin errors++; $display("FAIL reset_err_count got %0d want 0", bus.err_count); end
        checks++; if (bus.err_vec !== 6'b0) begin errors++; $display("FAIL reset_err_vec got %b want 000000", bus.err_vec); end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_good();
        int bad = 0;
        fault = 0;
        run_sweep();
        for (int n = 1; n <= 16; n++)
            if (trace[n] !== 2'((n - 1) / 4)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL good_drive_seq got %0d bad cycles want 0", bad); end
        checks++; if (trace[17] !== 2'b00) begin errors++; $display("FAIL good_drive_done got %b want 00", trace[17]); end
        checks++; if (done_cycle != 17) begin errors++; $display("FAIL good_done_cycle got %0d want 17", done_cycle); end
        checks++; if (bus.pass !== 1'b1) begin errors++; $display("FAIL good_pass got %b want 1", bus.pass); end
        checks++; if (bus.err_count !== 4'd0) begin errors++; $display("FAIL good_err_count got %0d want 0", bus.err_count); end
        checks++; if (bus.err_vec !== 6'b000000) begin errors++; $display("FAIL good_err_vec got %b want 000000", bus.err_vec); end
    endtask

    task automatic test_g_stuck();
        fault = 1;
        run_sweep();
        checks++; if (done_cycle != 17) begin errors++; $display("FAIL gstuck_done_cycle got %0d want 17", done_cycle); end
        checks++; if (bus.pass !== 1'b0) begin errors++; $display("FAIL gstuck_pass got %b want 0", bus.pass); end
        checks++; if (bus.err_count !== 4'd2) begin errors++; $display("FAIL gstuck_err_count got %0d want 2", bus.err_count); end
        checks++; if (bus.err_vec !== 6'b010000) begin errors++; $display("FAIL gstuck_err_vec got %b want 010000", bus.err_vec); end
    endtask

    task automatic test_saturate();
        fault = 2;
        run_sweep();
        checks++; if (bus.err_count !== 4'd15) begin errors++; $display("FAIL sat_err_count got %0d want 15", bus.err_count); end
        checks++; if (bus.err_vec !== 6'b111111) begin errors++; $display("FAIL sat_err_vec got %b want 111111", bus.err_vec); end
        checks++; if (bus.pass !== 1'b0) begin errors++; $display("FAIL sat_pass got %b want 0", bus.pass); end
    endtask

    task automatic test_mid_reset();
        // g stuck 0: vector 01 (sampled in cycle 8) leaves err_count=1
        fault = 1;
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;  // cycle 1
        repeat (9) @(negedge clk);         // cycle 10: SETTLE of vector 10
        checks++; if ({bus.drive_a, bus.drive_b, bus.busy} !== 3'b101) begin errors++; $display("FAIL midrst_pre got %b want 101", {bus.drive_a, bus.drive_b, bus.busy}); end
        checks++; if (bus.err_count !== 4'd1) begin errors++; $display("FAIL midrst_pre_cnt got %0d want 1", bus.err_count); end
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.busy, bus.drive_a, bus.drive_b} !== 3'b000) begin errors++; $display("FAIL midrst_outs got %b want 000", {bus.busy, bus.drive_a, bus.drive_b}); end
        checks++; if (bus.err_count !== 4'd0 || bus.err_vec !== 6'b0) begin errors++; $display("FAIL midrst_errs got %0d/%b want 0/000000", bus.err_count, bus.err_vec); end
        @(negedge clk) rst_n = 1'b1;
        fault = 0;
        run_sweep();
        checks++; if (done_cycle != 17) begin errors++; $display("FAIL midrst_rerun_done got %0d want 17", done_cycle); end
        checks++; if (bus.pass !== 1'b1 || bus.err_count !== 4'd0) begin errors++; $display("FAIL midrst_rerun_res got %b/%0d want 1/0", bus.pass, bus.err_count); end
    endtask

    task automatic test_start_held();
        int ndone = 0;
        int first = 0;
        int second = 0;
        logic busy18, busy19;
        fault = 0;
        busy18 = 1'bx; busy19 = 1'bx;
        @(negedge clk) bus.start = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (bus.done) begin
                ndone++;
                if (first == 0) first = n; else if (second == 0) second = n;
            end
            if (n == 18) busy18 = bus.busy;
            if (n == 19) busy19 = bus.busy;
            if (n == 30) bus.start = 1'b0;
        end
        checks++; if (first != 17) begin errors++; $display("FAIL held_first_done got %0d want 17", first); end
        checks++; if (busy18 !== 1'b0 || busy19 !== 1'b1) begin errors++; $display("FAIL held_restart got %b%b want 01", busy18, busy19); end
        checks++; if (second != 35 || ndone != 2) begin errors++; $display("FAIL held_second_done got %0d (n=%0d) want 35 (n=2)", second, ndone); end
    endtask

    task automatic test_c_stuck();
        fault = 3;
        run_sweep();
`ifdef GATE_CHK_STOP_ON_FAIL_EN
        checks++; if (done_cycle != 5) begin errors++; $display("FAIL cstuck_done_cycle got %0d want 5", done_cycle); end
        checks++; if (bus.err_count !== 4'd1) begin errors++; $display("FAIL cstuck_err_count got %0d want 1", bus.err_count); end
`else
        checks++; if (done_cycle != 17) begin errors++; $display("FAIL cstuck_done_cycle got %0d want 17", done_cycle); end
        checks++; if (bus.err_count !== 4'd3) begin errors++; $display("FAIL cstuck_err_count got %0d want 3", bus.err_count); end
`endif
        checks++; if (bus.err_vec !== 6'b000001) begin errors++; $display("FAIL cstuck_err_vec got %b want 000001", bus.err_vec); end
        checks++; if (bus.pass !== 1'b0) begin errors++; $display("FAIL cstuck_pass got %b want 0", bus.pass); end
    endtask

    initial begin
        bus.start = 1'b0;
        test_reset();
        test_good();
        test_g_stuck();
        test_saturate();
        test_mid_reset();
        test_start_held();
        test_c_stuck();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gate_response_checker.md
Name: gate_response_checker

Overview:
Synthesizable on-chip checker that forms the other end of the gate_logic stimulus path. It drives a/b into gate_logic through all four input combinations and samples the six gate outputs (c..h). It compares each output with the expected Boolean function and reports the result as pass/fail, an error count and a per-output mismatch bitmap. It sits beside gate_logic as a board-level built-in self-test for the lab design.

Parameters:
SETTLE_CYCLES, 2, clock cycles between driving a/b and sampling c..h; legal range 1..15.
ERR_W, 4, width of err_count.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a check sweep; sampled only in IDLE
drive_a  output  1  stimulus to gate_logic input a
drive_b  output  1  stimulus to gate_logic input b
c  input  1  gate_logic AND output (a&b)
d  input  1  gate_logic OR output (a|b)
e  input  1  gate_logic NAND output
f  input  1  gate_logic NOR output
g  input  1  gate_logic XOR output
h  input  1  gate_logic XNOR output
busy  output  1  high from first DRIVE cycle through last SAMPLE cycle
done  output  1  one-cycle pulse at end of sweep
pass  output  1  result of last sweep: 1 = no mismatch; held until next start
err_count  output  ERR_W  number of mismatching samples in last sweep, saturating
err_vec  output  6  sticky per-output mismatch flags, bit0=c ... bit5=h

Behaviour:
- One clock, clk; reset rst_n is asynchronous, active-low. Assertion at any time, including mid-sweep, forces IDLE immediately and clears drive_a, drive_b, busy, done, pass, err_count and err_vec to 0.
- FSM states: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE: drive_a/drive_b = 0. On start=1, clear err_count and err_vec, set vector index to 0, and go to DRIVE. start in any other state is ignored.
- DRIVE (1 cycle): {drive_a,drive_b} = vector index (order 00, 01, 10, 11, with a as MSB). Reload the settle counter with SETTLE_CYCLES-1, then go to SETTLE.
- SETTLE: hold drive values and decrement the counter. On 0, go to SAMPLE. Occupancy is exactly SETTLE_CYCLES cycles.
- SAMPLE (1 cycle): compare {h,g,f,e,d,c} against expected for the currently driven a,b.
  - OR each mismatch bit into err_vec.
  - Add the popcount of mismatches to err_count, saturating at 2^ERR_W-1 with no wrap.
  - If index = 3, go to DONE; else increment index and go to DRIVE.
- DONE (1 cycle): done=1; pass = (err_vec==0); drive_a/drive_b return to 0; next state IDLE.
- Latency: each vector takes SETTLE_CYCLES+2 cycles. done is high in cycle 4*(SETTLE_CYCLES+2)+1 after the clock edge that accepted start (17 for the default).
- busy = 1 in DRIVE, SETTLE and SAMPLE; 0 in IDLE and DONE.
- pass updates only in DONE. Between start and DONE it keeps its previous value but is not meaningful while busy=1.
- X or Z on c..h counts as a mismatch (case-equality compare).

Optional Feature:
Macro GATE_CHK_STOP_ON_FAIL_EN.
- Defined: the first SAMPLE with any mismatch goes straight to DONE. Remaining vectors are skipped; err_count and err_vec reflect only the vectors checked so far.
- Undefined: all four vectors are always checked, regardless of mismatches.

Test Plan:
1. Correct gate_logic model, SETTLE_CYCLES=2, pulse start -> drive sequence 00,01,10,11 each held 4 cycles; done pulse 17 cycles after start; pass=1, err_count=0, err_vec=6'b000000.
2. Model with g stuck at 0 -> mismatch at vectors 01 and 10; pass=0, err_count=2, err_vec=6'b010000.
3. All outputs inverted, ERR_W=4 -> 24 mismatches saturate, err_count=15; err_vec=6'b111111; pass=0.
4. rst_n driven low during SETTLE of vector 10 -> immediately busy=0, drive_a=drive_b=0, err_count=0; a new start runs a full, clean 17-cycle sweep.
5. start held high for 30 cycles -> a second sweep begins only after returning to IDLE (start re-sampled on the cycle after DONE); pulses while busy do not restart the sweep.
6. With GATE_CHK_STOP_ON_FAIL_EN and c stuck at 1 -> mismatch at vector 00; done 5 cycles after start; err_count=1, err_vec=6'b000001, pass=0.
